// File: rtl/uart_packet_tx.sv
// rtl/uart_packet_tx.sv - UART packet transmitter
// Serialises NUM_BYTES characters (start, data LSB first, optional parity, stop) on one TX line.
module uart_packet_tx #(
   parameter int NUM_BYTES    = 3,
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 5208,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic                           start_i,
   input  logic [NUM_BYTES*DATA_BITS-1:0] data_i,
   output logic                           tx_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [2:0]                     state_out_o
);

   localparam int PAY_W  = NUM_BYTES * DATA_BITS;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int BYTE_W = $clog2(NUM_BYTES + 1);

   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(NUM_BYTES - 1);
   localparam logic              ODD_PARITY  = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
   logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
   logic [PAY_W-1:0]    payload_q, payload_d;
   logic                parity_q, parity_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic                baud_tick;

   assign baud_tick = (baud_q == '0);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         payload_q  <= '0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         payload_q  <= payload_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      payload_d  = payload_q;
      parity_d   = parity_q;
      done_d     = 1'b0;
      tx_d       = 1'b1;

      if (state_q != S_IDLE) begin
         baud_d = baud_tick ? BAUD_RELOAD : (baud_q - BAUD_W'(1));
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_START;
               payload_d  = data_i;
               byte_idx_d = '0;
               bit_idx_d  = '0;
               parity_d   = 1'b0;
               baud_d     = BAUD_RELOAD;
            end
         end
         S_START: begin
            if (baud_tick) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            // The payload shifts right so the bit on the line is always payload_q[0].
            if (baud_tick) begin
               parity_d  = parity_q ^ payload_q[0];
               payload_d = payload_q >> 1;
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               state_d   = S_STOP;
               bit_idx_d = '0;
            end
         end
         S_STOP: begin
            // bit_idx counts stop bits here.
            if (baud_tick) begin
               if (bit_idx_q != LAST_STOP) begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end else begin
                  bit_idx_d = '0;
                  parity_d  = 1'b0;
                  if (byte_idx_q < LAST_BYTE) begin
                     byte_idx_d = byte_idx_q + BYTE_W'(1);
                     state_d    = S_START;
                  end else begin
                     state_d = S_IDLE;
                     baud_d  = '0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            baud_d     = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
         end
      endcase

      // tx is registered from the next state so the pin never glitches.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = payload_d[0];
         S_PARITY: tx_d = parity_d ^ ODD_PARITY;
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx_o        = tx_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign state_out_o = state_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb/tb_uart_packet_tx.sv - directed self-checking bench for uart_packet_tx
// Four instances cover 8N1 x3, 8E1, 8O1 and 8N2 x2, all at 4 clocks per bit.
module tb_uart_packet_tx;

   localparam int C = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [4];
   logic [23:0] data_a;
   logic [7:0]  data_b;
   logic [7:0]  data_c;
   logic [15:0] data_d;
   logic        tx_v   [4];
   logic        busy_v [4];
   logic        done_v [4];
   logic [2:0]  st_v   [4];

   logic        wtx   [256];
   logic        wdone [256];
   logic        wbusy [256];
   logic [2:0]  wst   [256];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_packet_tx #(.NUM_BYTES(3), .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clock_i(clk), .reset_i(rst), .start_i(start_v[0]), .data_i(data_a),
      .tx_o(tx_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .state_out_o(st_v[0]));
   uart_packet_tx #(.NUM_BYTES(1), .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u_8e1 (
      .clock_i(clk), .reset_i(rst), .start_i(start_v[1]), .data_i(data_b),
      .tx_o(tx_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .state_out_o(st_v[1]));
   uart_packet_tx #(.NUM_BYTES(1), .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u_8o1 (
      .clock_i(clk), .reset_i(rst), .start_i(start_v[2]), .data_i(data_c),
      .tx_o(tx_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .state_out_o(st_v[2]));
   uart_packet_tx #(.NUM_BYTES(2), .DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clock_i(clk), .reset_i(rst), .start_i(start_v[3]), .data_i(data_d),
      .tx_o(tx_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]), .state_out_o(st_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns just after acceptance edge E with start still high.
   task automatic accept(input int s);
      @(negedge clk);
      start_v[s] = 1'b1;
      @(posedge clk);
   endtask

   // Sample k is the cycle between edges E+k and E+k+1.
   task automatic capture(input int s, input int ncyc, input int disturb_k, input bit hold);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (!hold) start_v[s] = 1'b0;
         if (k == disturb_k) begin
            start_v[s] = 1'b1;
            data_a     = 24'hFF_FF_FF;
         end
         wtx[k]   = tx_v[s];
         wdone[k] = done_v[s];
         wbusy[k] = busy_v[s];
         wst[k]   = st_v[s];
      end
   endtask

   function automatic logic [7:0] char_at(input int base, input int f, input int j);
      logic [7:0] c;
      for (int b = 0; b < 8; b++) c[b] = wtx[base + j*f + (1+b)*C + 2];
      return c;
   endfunction

   function automatic int count_done(input int n);
      int cnt = 0;
      for (int k = 0; k < n; k++) if (wdone[k]) cnt++;
      return cnt;
   endfunction

   task automatic wait_idle(input int s, input int max_cyc);
      for (int i = 0; i < max_cyc && busy_v[s]; i++) @(negedge clk);
      check("idle_timeout", 32'(busy_v[s]), 32'd0);
   endtask

   initial begin
      int ones;
      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
      data_a = 24'h0;
      data_b = 8'h0;
      data_c = 8'h0;
      data_d = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_tx",    32'(tx_v[0]),   32'd1);
      check("rst_busy",  32'(busy_v[0]), 32'd0);
      check("rst_done",  32'(done_v[0]), 32'd0);
      check("rst_state", 32'(st_v[0]),   32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic 3-byte 8N1 packet
      data_a = 24'hA5_3C_0F;
      accept(0);
      capture(0, 130, -1, 1'b0);
      check("acc_state", 32'(wst[0]),   32'd1);
      check("acc_busy",  32'(wbusy[0]), 32'd1);
      check("acc_tx",    32'(wtx[0]),   32'd0);
      check("char0", 32'(char_at(0, 40, 0)), 32'h0F);
      check("char1", 32'(char_at(0, 40, 1)), 32'h3C);
      check("char2", 32'(char_at(0, 40, 2)), 32'hA5);
      check("stop0",     32'(wtx[39]), 32'd1);
      check("start1",    32'(wtx[40]), 32'd0);
      check("done_119",  32'(wdone[119]), 32'd0);
      check("done_120",  32'(wdone[120]), 32'd1);
      check("done_cnt",  32'(count_done(130)), 32'd1);
      check("busy_119",  32'(wbusy[119]), 32'd1);
      check("busy_120",  32'(wbusy[120]), 32'd0);
      check("tx_after",  32'(wtx[125]), 32'd1);
      check("st_after",  32'(wst[125]), 32'd0);

      // Even and odd parity on 0x07
      data_b = 8'h07;
      accept(1);
      capture(1, 50, -1, 1'b0);
      check("even_char",  32'(char_at(0, 44, 0)), 32'h07);
      check("even_par",   32'(wtx[38]),   32'd1);
      check("even_done43", 32'(wdone[43]), 32'd0);
      check("even_done44", 32'(wdone[44]), 32'd1);
      data_c = 8'h07;
      accept(2);
      capture(2, 50, -1, 1'b0);
      check("odd_char",   32'(char_at(0, 44, 0)), 32'h07);
      check("odd_par",    32'(wtx[38]),   32'd0);
      check("odd_done44", 32'(wdone[44]), 32'd1);

      // Two stop bits, two characters
      data_d = 16'h81_55;
      accept(3);
      capture(3, 100, -1, 1'b0);
      check("st2_char0", 32'(char_at(0, 44, 0)), 32'h55);
      check("st2_char1", 32'(char_at(0, 44, 1)), 32'h81);
      ones = 0;
      for (int k = 36; k < 44; k++) if (wtx[k]) ones++;
      check("st2_stop_ones", 32'(ones), 32'd8);
      check("st2_bit7",  32'(wtx[35]), 32'd0);
      check("st2_start", 32'(wtx[44]), 32'd0);
      check("st2_done",  32'(wdone[88]), 32'd1);
      check("st2_dcnt",  32'(count_done(100)), 32'd1);

      // start and data changes while busy are ignored
      data_a = 24'h12_34_56;
      accept(0);
      capture(0, 200, 50, 1'b0);
      check("busy_char0", 32'(char_at(0, 40, 0)), 32'h56);
      check("busy_char1", 32'(char_at(0, 40, 1)), 32'h34);
      check("busy_char2", 32'(char_at(0, 40, 2)), 32'h12);
      check("busy_done",  32'(wdone[120]), 32'd1);
      check("busy_dcnt",  32'(count_done(200)), 32'd1);
      check("busy_state", 32'(wst[199]), 32'd0);
      check("busy_tx",    32'(wtx[190]), 32'd1);

      // Asynchronous reset during a low data bit (bit 4 of 0x0F)
      data_a = 24'hA5_3C_0F;
      accept(0);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (21) @(negedge clk);
      check("mid_tx_low", 32'(tx_v[0]), 32'd0);
      rst = 1'b1;
      #1;
      check("arst_tx",    32'(tx_v[0]),   32'd1);
      check("arst_busy",  32'(busy_v[0]), 32'd0);
      check("arst_done",  32'(done_v[0]), 32'd0);
      check("arst_state", 32'(st_v[0]),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      accept(0);
      capture(0, 130, -1, 1'b0);
      check("post_char0", 32'(char_at(0, 40, 0)), 32'h0F);
      check("post_char1", 32'(char_at(0, 40, 1)), 32'h3C);
      check("post_char2", 32'(char_at(0, 40, 2)), 32'hA5);
      check("post_done",  32'(wdone[120]), 32'd1);

      // Back-to-back with start held high
      data_a = 24'hC3_81_7E;
      accept(0);
      capture(0, 250, -1, 1'b1);
      check("b2b_done1",  32'(wdone[120]), 32'd1);
      check("b2b_gap_tx", 32'(wtx[120]),   32'd1);
      check("b2b_gap_st", 32'(wst[120]),   32'd0);
      check("b2b_re_tx",  32'(wtx[121]),   32'd0);
      check("b2b_re_st",  32'(wst[121]),   32'd1);
      check("b2b_done2",  32'(wdone[241]), 32'd1);
      check("b2b_dcnt",   32'(count_done(250)), 32'd2);
      check("b2b_p1c0",   32'(char_at(0, 40, 0)),   32'h7E);
      check("b2b_p2c2",   32'(char_at(121, 40, 2)), 32'hC3);
      start_v[0] = 1'b0;
      wait_idle(0, 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_packet_tx.md
# uart_packet_tx

Parametrised UART packet transmitter. It serialises a word of NUM_BYTES characters onto one TX line, each character framed with a start bit, optional parity and 1 or 2 stop bits. Bit timing comes from an internal baud counter running off the system clock, so no separate baud clock is needed. The block sits between the sensor/command logic and the board TX pin, and reports packet completion with a single-cycle pulse.

## Interface
- NUM_BYTES, 3: characters per packet (1..16).
- DATA_BITS, 8: data bits per character (5..8).
- CLKS_PER_BIT, 5208: clock cycles per bit; 50 MHz / 9600 baud (2..65535).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per character (1 or 2).

- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  packet request; sampled only in IDLE.
- data  in  NUM_BYTES*DATA_BITS  packet payload; character k = data[k*DATA_BITS +: DATA_BITS].
- tx  out  1  serial line; idle high.
- busy  out  1  high from the accepting edge until return to IDLE.
- done  out  1  one-cycle pulse when the last stop bit completes.
- state_out  out  3  current state encoding, for debug/LEDs.

## Operation
- States and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE
  - tx=1, busy=0.
  - If start=1 at an edge: latch data into an internal payload register, clear the byte index, load the baud counter, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - Sends DATA_BITS bits, LSB first, of character[byte_index].
  - Each bit is held for CLKS_PER_BIT cycles.
  - After the last bit, go to PARITY if PARITY≠0, otherwise go to STOP.
- PARITY
  - Even mode: the bit makes the count of ones across data plus parity even, i.e. the XOR of the data bits.
  - Odd mode: the inverse of that.
  - Held for CLKS_PER_BIT cycles, then go to STOP.
- STOP
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - If byte_index < NUM_BYTES-1: increment byte_index and go to START. There is no idle gap between characters.
  - Otherwise: go to IDLE and pulse done.
- Characters go out in order 0 to NUM_BYTES-1.
- The payload is frozen at acceptance; changes on data while busy have no effect.
- start while busy is ignored. There is no queuing.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, counts down to 0, reloads at each bit boundary.
  - Bit index: $clog2(DATA_BITS+1) bits.
  - Byte index: $clog2(NUM_BYTES+1) bits.
  - No wrap beyond these terminal values is permitted.
- An illegal state_out value (5..7) returns to IDLE on the next edge with tx=1.

## Timing
- Reset values: tx=1, busy=0, done=0, state_out=0. Counters and byte index are 0.
- Reset applies immediately, asynchronously, including mid-frame. tx returns high without finishing the character.
- Acceptance:
  - Edge E samples start=1 in IDLE.
  - From E on: state_out=1, busy=1, tx=0.
  - The start bit starts one cycle after start is presented. This is the latency.
- Character length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Packet length: NUM_BYTES * F cycles, from edge E to the edge that returns to IDLE.
- done
  - Asserted on exactly the edge that enters IDLE; deasserts after one cycle.
  - busy falls on that same edge.
- start held high through done: the new packet is accepted at the first IDLE edge after done rises. This gives exactly one idle (tx=1) cycle between packets.
- start pulse of one cycle in IDLE is sufficient. start pulses outside IDLE are lost.

## Test plan
- Basic packet
  - Setup: CLKS_PER_BIT=4, NUM_BYTES=3, 8N1, data=24'hA5_3C_0F, single start pulse.
  - Required: character bytes 0x0F, 0x3C, 0xA5 in that order; each frame is 40 cycles, 120 cycles total; done pulses once at cycle 120; tx=1 afterwards.
- Parity
  - Setup: PARITY=1, then PARITY=2; send 8'h07.
  - Required: parity bit 1 for even, 0 for odd. Frame is 44 cycles at CLKS_PER_BIT=4.
- Two stop bits
  - Setup: STOP_BITS=2, NUM_BYTES=2.
  - Required: 8 high cycles between characters; total 2*44 cycles.
- Busy behaviour
  - Setup: pulse start mid-packet, and change data mid-packet.
  - Required: no restart; the transmitted bits match the payload latched at acceptance.
- Reset mid-operation
  - Setup: assert reset during a DATA bit that is driving 0.
  - Required: tx=1 with no clock edge; busy=0, done=0, state_out=0. A start after reset yields a clean full packet.
- Back-to-back
  - Setup: hold start=1 continuously.
  - Required: exactly one idle cycle after each done; done pulses every NUM_BYTES*F+1 cycles.
